// File: rtl/alsu_ctrl_pkg.sv
// Shared types and width constants for the ALSU request front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alsu_ctrl_pkg;

    localparam int DATA_W  = 4;
    localparam int SEL_W   = 6;
    localparam int NUM_REQ = 2;

    // Width of the hold-cycle counter; EXEC_CYCLES is limited to 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // One requester's operation as presented to the ALSU.
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } op_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way priority picker; one-hot grant from valids and the current priority bit.
// Latency: purely combinational, zero cycles.
// Backpressure: grant forced to zero while En is low (parent is busy).
//
// Ports:
//   Req_Valid  in  2  pending requests
//   Prio       in  1  index of the requester that wins a tie
//   En         in  1  arbitration allowed this cycle
//   Grant      out 2  one-hot winner, or zero
module rr_arbiter_2 (
    input  logic [1:0] Req_Valid,
    input  logic       Prio,
    input  logic       En,
    output logic [1:0] Grant
);

    always_comb begin
        Grant = 2'b00;
        if (En) begin
            case (Req_Valid)
                2'b01:   Grant = 2'b01;
                2'b10:   Grant = 2'b10;
                2'b11:   Grant = Prio ? 2'b10 : 2'b01;
                default: Grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alsu_request_arbiter.sv
// Shares one combinational ALSU between two requesters with round-robin arbitration.
// Latency: accept in cycle N -> Rsp_Valid from cycle N+1+EXEC_CYCLES.
// Backpressure: Req_Ready only in IDLE; Rsp_Valid held until Rsp_Ready of the winner.
//
// Ports:
//   Clk, Rst                      clock, synchronous active-high reset
//   Req_Valid/Ready/A/B/Sel       request handshake, requester i in lane i
//   Rsp_Valid/Ready               response handshake, only the winner's bit is used
//   Rsp_Out/Carry/Neg             registered ALSU result and flags
//   Rsp_Zero                      registered zero flag (only with ALSU_ZERO_FLAG_EN)
//   Busy                          high outside IDLE
//   ALSU_A/B/Sel, ALSU_Out/...    connection to the shared combinational ALSU
// Optional feature macro: ALSU_ZERO_FLAG_EN adds the Rsp_Zero output.
module alsu_request_arbiter
    import alsu_ctrl_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int RR_INIT     = 0
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [NUM_REQ-1:0]         Req_Valid,
    output logic [NUM_REQ-1:0]         Req_Ready,
    input  logic [NUM_REQ*DATA_W-1:0]  Req_A,
    input  logic [NUM_REQ*DATA_W-1:0]  Req_B,
    input  logic [NUM_REQ*SEL_W-1:0]   Req_Sel,
    output logic [NUM_REQ-1:0]         Rsp_Valid,
    input  logic [NUM_REQ-1:0]         Rsp_Ready,
    output logic [DATA_W-1:0]          Rsp_Out,
    output logic                       Rsp_Carry,
    output logic                       Rsp_Neg,
`ifdef ALSU_ZERO_FLAG_EN
    output logic                       Rsp_Zero,
`endif
    output logic                       Busy,
    output logic [DATA_W-1:0]          ALSU_A,
    output logic [DATA_W-1:0]          ALSU_B,
    output logic [SEL_W-1:0]           ALSU_Sel,
    input  logic [DATA_W-1:0]          ALSU_Out,
    input  logic                       ALSU_Carry_Out,
    input  logic                       ALSU_Negative_Sign_Flag
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic              prio;
    logic              gnt_q;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        grant;
    logic              accept;
    logic              capture;
    logic              rsp_done;
    op_t               req_op [NUM_REQ];
    op_t               win_op;

    // Unpack the flat request buses into per-requester operations.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_op[i].a   = Req_A[i*DATA_W +: DATA_W];
            req_op[i].b   = Req_B[i*DATA_W +: DATA_W];
            req_op[i].sel = Req_Sel[i*SEL_W +: SEL_W];
        end
    end

    rr_arbiter_2 u_rr_arbiter_2 (
        .Req_Valid (Req_Valid),
        .Prio      (prio),
        .En        (state == IDLE),
        .Grant     (grant)
    );

    assign win_op = req_op[grant[1]];

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        Req_Ready = grant;
        Rsp_Valid = '0;
        Busy      = (state != IDLE);
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (grant != 2'b00) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                Rsp_Valid[gnt_q] = 1'b1;
                // Only the winner's ready completes the response.
                if (Rsp_Ready[gnt_q]) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand, counter, result and priority registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            prio      <= 1'(RR_INIT);
            gnt_q     <= 1'b0;
            cnt       <= '0;
            ALSU_A    <= '0;
            ALSU_B    <= '0;
            ALSU_Sel  <= '0;
            Rsp_Out   <= '0;
            Rsp_Carry <= 1'b0;
            Rsp_Neg   <= 1'b0;
`ifdef ALSU_ZERO_FLAG_EN
            Rsp_Zero  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                gnt_q    <= grant[1];
                ALSU_A   <= win_op.a;
                ALSU_B   <= win_op.b;
                ALSU_Sel <= win_op.sel;
                cnt      <= CNT_LOAD;
            end else if (state == EXEC && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (capture) begin
                Rsp_Out   <= ALSU_Out;
                Rsp_Carry <= ALSU_Carry_Out;
                Rsp_Neg   <= ALSU_Negative_Sign_Flag;
`ifdef ALSU_ZERO_FLAG_EN
                Rsp_Zero  <= (ALSU_Out == '0);
`endif
            end

            // Priority rotates on response completion only, never on a grant.
            if (rsp_done) begin
                prio <= ~gnt_q;
            end
        end
    end

endmodule

// File: tb/tb_alsu_request_arbiter.sv
// Self-checking bench: two instances (EXEC_CYCLES=1/RR_INIT=0 and EXEC_CYCLES=4/RR_INIT=1)
// driven by directed and random transactions against a transaction-level model.
module tb_alsu_request_arbiter;

    logic        clk;
    logic        rst       [2];
    logic [1:0]  req_valid [2];
    logic [1:0]  req_ready [2];
    logic [7:0]  req_a     [2];
    logic [7:0]  req_b     [2];
    logic [11:0] req_sel   [2];
    logic [1:0]  rsp_valid [2];
    logic [1:0]  rsp_ready [2];
    logic [3:0]  rsp_out   [2];
    logic        rsp_carry [2];
    logic        rsp_neg   [2];
`ifdef ALSU_ZERO_FLAG_EN
    logic        rsp_zero  [2];
`endif
    logic        busy      [2];
    logic [3:0]  alsu_a    [2];
    logic [3:0]  alsu_b    [2];
    logic [5:0]  alsu_sel  [2];
    logic [3:0]  alsu_out  [2];
    logic        alsu_c    [2];
    logic        alsu_n    [2];

    logic        force_en;
    logic [5:0]  force_val;   // {carry, neg, out}

    int n_tests;
    int n_fail;
    int exp_prio [2];

    // Environment ALSU: add, sub, and, or, xor, not-A; or a forced value.
    function automatic logic [5:0] alsu_fn(input logic [3:0] a, input logic [3:0] b,
                                           input logic [5:0] s, input logic fe,
                                           input logic [5:0] fv);
        logic [4:0] t;
        logic [5:0] r;
        t = '0;
        r = '0;
        if (fe) begin
            r = fv;
        end else begin
            case (s[2:0])
                3'd0: begin t = {1'b0, a} + {1'b0, b}; r = {t[4], 1'b0, t[3:0]}; end
                3'd1: begin t = {1'b0, a} - {1'b0, b}; r = {t[4], (a < b), t[3:0]}; end
                3'd2: r = {2'b00, a & b};
                3'd3: r = {2'b00, a | b};
                3'd4: r = {2'b00, a ^ b};
                default: r = {2'b00, ~a};
            endcase
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        alsu_request_arbiter #(
            .EXEC_CYCLES ((gi == 0) ? 1 : 4),
            .RR_INIT     ((gi == 0) ? 0 : 1)
        ) u_dut (
            .Clk                     (clk),
            .Rst                     (rst[gi]),
            .Req_Valid               (req_valid[gi]),
            .Req_Ready               (req_ready[gi]),
            .Req_A                   (req_a[gi]),
            .Req_B                   (req_b[gi]),
            .Req_Sel                 (req_sel[gi]),
            .Rsp_Valid               (rsp_valid[gi]),
            .Rsp_Ready               (rsp_ready[gi]),
            .Rsp_Out                 (rsp_out[gi]),
            .Rsp_Carry               (rsp_carry[gi]),
            .Rsp_Neg                 (rsp_neg[gi]),
`ifdef ALSU_ZERO_FLAG_EN
            .Rsp_Zero                (rsp_zero[gi]),
`endif
            .Busy                    (busy[gi]),
            .ALSU_A                  (alsu_a[gi]),
            .ALSU_B                  (alsu_b[gi]),
            .ALSU_Sel                (alsu_sel[gi]),
            .ALSU_Out                (alsu_out[gi]),
            .ALSU_Carry_Out          (alsu_c[gi]),
            .ALSU_Negative_Sign_Flag (alsu_n[gi])
        );
        assign {alsu_c[gi], alsu_n[gi], alsu_out[gi]} =
            alsu_fn(alsu_a[gi], alsu_b[gi], alsu_sel[gi], force_en, force_val);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full transaction on instance d; starts and ends just after a negedge.
    task automatic do_txn(input int d, input logic [1:0] v, input logic [7:0] a,
                          input logic [7:0] b, input logic [11:0] s, input int hold);
        int         g;
        int         n;
        int         lat;
        logic [1:0] oh;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [5:0] es;
        logic [5:0] er;
        g   = (v == 2'b11) ? exp_prio[d] : (v[1] ? 1 : 0);
        oh  = (g == 1) ? 2'b10 : 2'b01;
        lat = (d == 0) ? 2 : 5;
        ea  = a[g*4 +: 4];
        eb  = b[g*4 +: 4];
        es  = s[g*6 +: 6];
        er  = alsu_fn(ea, eb, es, force_en, force_val);
        req_valid[d] = v;
        req_a[d]     = a;
        req_b[d]     = b;
        req_sel[d]   = s;
        rsp_ready[d] = ~oh;   // loser's ready must be ignored throughout
        #1;
        n_tests++;
        if (req_ready[d] !== oh) begin
            n_fail++;
            $display("FAIL grant d%0d: req_ready=%b expected %b", d, req_ready[d], oh);
        end
        @(negedge clk);
        n = 1;
        while (rsp_valid[d] === 2'b00 && n < 40) begin
            n_tests++;
            if (req_ready[d] !== 2'b00 || busy[d] !== 1'b1 || alsu_a[d] !== ea ||
                alsu_b[d] !== eb || alsu_sel[d] !== es) begin
                n_fail++;
                $display("FAIL exec_hold d%0d: ready=%b busy=%b a=%h b=%h sel=%h expected 00 1 %h %h %h",
                         d, req_ready[d], busy[d], alsu_a[d], alsu_b[d], alsu_sel[d], ea, eb, es);
            end
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n != lat) begin
            n_fail++;
            $display("FAIL latency d%0d: %0d cycles expected %0d", d, n, lat);
        end
        for (int h = 0; h <= hold; h++) begin
            n_tests++;
            if (rsp_valid[d] !== oh || rsp_out[d] !== er[3:0] || rsp_carry[d] !== er[5] ||
                rsp_neg[d] !== er[4] || req_ready[d] !== 2'b00) begin
                n_fail++;
                $display("FAIL response d%0d: vld=%b out=%h c=%b n=%b rdy=%b expected %b %h %b %b 00",
                         d, rsp_valid[d], rsp_out[d], rsp_carry[d], rsp_neg[d], req_ready[d],
                         oh, er[3:0], er[5], er[4]);
            end
`ifdef ALSU_ZERO_FLAG_EN
            n_tests++;
            if (rsp_zero[d] !== (er[3:0] == 4'h0)) begin
                n_fail++;
                $display("FAIL zero_flag d%0d: %b expected %b", d, rsp_zero[d], (er[3:0] == 4'h0));
            end
`endif
            if (h < hold) @(negedge clk);
        end
        rsp_ready[d] = oh;
        @(negedge clk);
        exp_prio[d] = 1 - g;
        n_tests++;
        if (busy[d] !== 1'b0 || rsp_valid[d] !== 2'b00) begin
            n_fail++;
            $display("FAIL rsp_done d%0d: busy=%b vld=%b expected 0 00", d, busy[d], rsp_valid[d]);
        end
        req_valid[d] = 2'b00;
        rsp_ready[d] = 2'b00;
    endtask

    task automatic test_reset(input int d);
        rst[d]       = 1'b1;
        req_valid[d] = 2'b00;
        rsp_ready[d] = 2'b00;
        repeat (2) @(negedge clk);
        rst[d] = 1'b0;
        exp_prio[d] = (d == 0) ? 0 : 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (req_ready[d] !== 2'b00 || rsp_valid[d] !== 2'b00 || busy[d] !== 1'b0 ||
                rsp_out[d] !== 4'h0 || rsp_carry[d] !== 1'b0 || rsp_neg[d] !== 1'b0 ||
                alsu_a[d] !== 4'h0 || alsu_b[d] !== 4'h0 || alsu_sel[d] !== 6'h00) begin
                n_fail++;
                $display("FAIL reset_idle d%0d: rdy=%b vld=%b busy=%b out=%h c=%b n=%b a=%h b=%h sel=%h expected all zero",
                         d, req_ready[d], rsp_valid[d], busy[d], rsp_out[d], rsp_carry[d],
                         rsp_neg[d], alsu_a[d], alsu_b[d], alsu_sel[d]);
            end
        end
    endtask

    task automatic test_single;
        do_txn(0, 2'b01, 8'h03, 8'h05, 12'h000, 5);
    endtask

    task automatic test_contention;
        test_reset(0);
        for (int k = 0; k < 4; k++) begin
            do_txn(0, 2'b11, 8'($urandom), 8'($urandom), 12'($urandom), k % 2);
        end
    endtask

    task automatic test_flags;
        force_en  = 1'b1;
        force_val = {1'b1, 1'b1, 4'hF};
        do_txn(0, 2'b10, 8'h12, 8'h34, 12'h041, 1);
        force_val = {1'b0, 1'b0, 4'h0};
        do_txn(0, 2'b01, 8'h56, 8'h78, 12'h003, 0);
        force_en = 1'b0;
    endtask

    task automatic test_exec4;
        do_txn(1, 2'b01, 8'h9A, 8'h21, 12'h0C1, 2);
    endtask

    task automatic test_reset_exec;
        req_valid[1] = 2'b01;
        req_a[1]     = 8'h0A;
        req_b[1]     = 8'h0B;
        req_sel[1]   = 12'h002;
        #1;
        n_tests++;
        if (req_ready[1] !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_exec_accept: req_ready=%b expected 01", req_ready[1]);
        end
        repeat (2) @(negedge clk);
        rst[1]       = 1'b1;
        req_valid[1] = 2'b00;
        @(negedge clk);
        n_tests++;
        if (busy[1] !== 1'b0 || rsp_valid[1] !== 2'b00 || alsu_a[1] !== 4'h0 || alsu_sel[1] !== 6'h00) begin
            n_fail++;
            $display("FAIL rst_exec_clear: busy=%b vld=%b a=%h sel=%h expected 0 00 0 00",
                     busy[1], rsp_valid[1], alsu_a[1], alsu_sel[1]);
        end
        rst[1] = 1'b0;
        exp_prio[1] = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (busy[1] !== 1'b0 || rsp_valid[1] !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_exec_quiet: busy=%b vld=%b expected 0 00", busy[1], rsp_valid[1]);
            end
        end
        do_txn(1, 2'b11, 8'h47, 8'h13, 12'h040, 0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 24; k++) begin
            int d;
            int gap;
            d   = $urandom_range(0, 1);
            gap = $urandom_range(0, 2);
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                n_tests++;
                if (req_ready[d] !== 2'b00 || busy[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_gap d%0d: rdy=%b busy=%b expected 00 0", d, req_ready[d], busy[d]);
                end
            end
            do_txn(d, 2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom),
                   12'($urandom), $urandom_range(0, 3));
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        force_en  = 1'b0;
        force_val = '0;
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            req_valid[d] = 2'b00;
            rsp_ready[d] = 2'b00;
            req_a[d]     = '0;
            req_b[d]     = '0;
            req_sel[d]   = '0;
            exp_prio[d]  = 0;
        end
        @(negedge clk);
        test_reset(0);
        test_reset(1);
        test_single;
        test_contention;
        test_flags;
        test_exec4;
        test_reset_exec;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
